// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states and nibble width.
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a producer (master) and the adder (slave).
interface nibble_serial_adder_if
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIB_W * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_hc283.sv
// hc283 cell: 4-bit binary full adder with carry in/out, purely combinational.
module hc283 (
    input  logic [3:0] inA,
    input  logic [3:0] inB,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout
);

    assign {cout, out} = {1'b0, inA} + {1'b0, inB} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// W-bit add/subtract through one shared hc283, one nibble per clock, LSB nibble first.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int unsigned W  = NIB_W * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            ovf_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] add_out;
    logic             add_cout;

    always_comb begin
        a_nib = a_reg[idx*NIB_W +: NIB_W];
        b_nib = b_reg[idx*NIB_W +: NIB_W];
    end

    hc283 u_add (
        .inA  (a_nib),
        .inB  (b_nib),
        .cin  (carry),
        .out  (add_out),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        a_reg        <= bus.op_a;
                        b_reg        <= bus.op_b ^ {W{bus.op_sub}};
                        carry        <= bus.op_sub;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx*NIB_W +: NIB_W] <= add_out;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        // The top nibble's MSB is only known here, so ovf is resolved on this edge.
                        ovf_reg <= (a_reg[W-1] == b_reg[W-1]) &&
                                   (add_out[NIB_W-1] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = carry;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES = 4).
module tb_nibble_serial_adder;

    localparam int unsigned NIBBLES = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation, verify fixed latency and result, optionally hand off.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf, input logic handoff);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        if (handoff) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            check({tag, "_handoff_ov"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_handoff_ir"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        int handoffs;
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        run_op("sub_basic",  16'h5555, 16'h1234, 1'b1, 16'h4321, 1'b1, 1'b0, 1'b1);
        run_op("add_negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Back-pressure: hold the result while inputs churn.
        run_op("hold", 16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.op_a     = 16'(i * 16'h1111);
            bus.op_b     = 16'hA5A5 ^ 16'(i);
            bus.op_sub   = i[0];
            @(posedge clk);
            #1;
            check("hold_sum", 32'(bus.sum), 32'h0FFF);
            check("hold_cout", 32'(bus.cout), 32'd0);
            check("hold_ovf", 32'(bus.ovf), 32'd0);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        handoffs = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            if (bus.out_valid && bus.out_ready) handoffs++;
            #1;
        end
        bus.out_ready = 1'b0;
        check("hold_handoffs", 32'(handoffs), 32'd1);
        check("hold_after_ir", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of RUN at idx=2.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = 16'h1111;
        bus.op_b     = 16'h2222;
        bus.op_sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_pre_ir", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_ir", 32'(bus.in_ready), 32'd1);
        check("midrst_ov", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        handoffs = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) handoffs++;
        end
        check("midrst_no_result", 32'(handoffs), 32'd0);
        run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
